// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed 8N1 serial transmitter.
package uart_tx_fifo_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef logic [DATA_BITS-1:0] tx_byte_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU write path, configuration and status bundle of the serial transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DIV_W   = 32
);

  logic [DIV_W-1:0] cfg_divider;
  logic             wr;
  logic [7:0]       data;
  logic             clr_ovf;
  logic             ser_tx;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] level;
  logic             busy;
  logic             overflow;

  modport master (
    output cfg_divider, wr, data, clr_ovf,
    input  ser_tx, full, empty, level, busy, overflow
  );

  modport slave (
    input  cfg_divider, wr, data, clr_ovf,
    output ser_tx, full, empty, level, busy, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous circular byte FIFO with registered full/empty/level and
// first-word fall-through read data.
module uart_tx_fifo_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  tx_byte_t         i_din,
  output tx_byte_t         o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  tx_byte_t           r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [FIFO_AW:0]   w_level_nxt;
  logic               r_full;
  logic               r_empty;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_nxt = r_level + (FIFO_AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (FIFO_AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (FIFO_AW+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each lasting div_q clocks, with back-to-back frames when bytes are queued.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DIV_W   = 32
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_fifo_if.slave  bus
);

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [DIV_W-1:0]     r_div_q;
  logic [DIV_W-1:0]     w_div_nxt;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     w_cnt_nxt;
  logic [DIV_W-1:0]     w_div_eff;
  tx_byte_t             r_sh;
  tx_byte_t             w_sh_nxt;
  logic [BIT_IDX_W-1:0] r_bit;
  logic [BIT_IDX_W-1:0] w_bit_nxt;
  logic                 r_ser_tx;
  logic                 w_ser_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_overflow;
  logic                 w_overflow_nxt;
  logic                 w_tick;
  logic                 w_load;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_empty_nxt;
  tx_byte_t             w_fifo_dout;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [FIFO_AW:0]     w_fifo_level;

  uart_tx_fifo_byte_fifo #(.FIFO_AW(FIFO_AW)) u_byte_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (bus.wr),
    .i_pop   (w_pop),
    .i_din   (bus.data),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign w_div_eff = (bus.cfg_divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_divider;
  assign w_tick    = (r_cnt == '0);

  // Next-state, datapath and registered-output values.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div_q;
    w_cnt_nxt      = r_cnt;
    w_sh_nxt       = r_sh;
    w_bit_nxt      = r_bit;
    w_load         = 1'b0;
    w_pop          = 1'b0;
    w_ser_nxt      = 1'b1;
    w_busy_nxt     = 1'b0;
    w_overflow_nxt = r_overflow;
    w_accept       = 1'b0;
    w_empty_nxt    = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_load = ~w_fifo_empty;
      end
      ST_START: begin
        if (w_tick) begin
          w_cnt_nxt   = r_div_q - DIV_W'(1);
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_nxt = r_div_q - DIV_W'(1);
          if (r_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = ST_STOP;
          end else begin
            w_sh_nxt  = r_sh >> 1;
            w_bit_nxt = r_bit + BIT_IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit == BIT_IDX_W'(STOP_BITS - 1)) begin
            w_state_nxt = ST_IDLE;
            w_load      = ~w_fifo_empty;
          end else begin
            w_cnt_nxt = r_div_q - DIV_W'(1);
            w_bit_nxt = r_bit + BIT_IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame start: pop the head and latch the divider for the whole frame.
    if (w_load) begin
      w_pop       = 1'b1;
      w_sh_nxt    = w_fifo_dout;
      w_div_nxt   = w_div_eff;
      w_cnt_nxt   = w_div_eff - DIV_W'(1);
      w_state_nxt = ST_START;
    end

    case (w_state_nxt)
      ST_START: w_ser_nxt = 1'b0;
      ST_DATA:  w_ser_nxt = w_sh_nxt[0];
      default:  w_ser_nxt = 1'b1;
    endcase

    w_accept    = bus.wr & ~w_fifo_full;
    w_empty_nxt = ~w_accept &
                  (w_fifo_empty | (w_pop & (w_fifo_level == (FIFO_AW+1)'(1))));
    w_busy_nxt  = (w_state_nxt != ST_IDLE) | ~w_empty_nxt;

    if (bus.wr & w_fifo_full) w_overflow_nxt = 1'b1;
    else if (bus.clr_ovf)     w_overflow_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_div_q    <= DIV_W'(MIN_DIV);
      r_cnt      <= '0;
      r_sh       <= '0;
      r_bit      <= '0;
      r_ser_tx   <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_q    <= w_div_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sh       <= w_sh_nxt;
      r_bit      <= w_bit_nxt;
      r_ser_tx   <= w_ser_nxt;
      r_busy     <= w_busy_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign bus.ser_tx   = r_ser_tx;
  assign bus.full     = w_fifo_full;
  assign bus.empty    = w_fifo_empty;
  assign bus.level    = w_fifo_level;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of queued bytes checked by a line-level
// receiver model that verifies every cycle of every frame.
module tb_uart_tx_fifo;

  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned DIV_W   = 32;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) bus ();

  uart_tx_fifo #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   n_checks    = 0;
  int   n_pass      = 0;
  int   cyc         = 0;
  int   frames_done = 0;
  exp_t sb[$];
  int   starts[$];
  bit   rx_en   = 1'b0;
  bit   rx_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d reached, required finish before 90000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  // Receiver model: every cycle of the frame must match the expected line level.
  always begin : rx_model
    exp_t       e;
    int         errs;
    int         bitn;
    logic [7:0] got;
    logic       exp_bit;
    bit         aborted;
    @(negedge clk);
    if (rx_en && bus.ser_tx === 1'b0) begin
      starts.push_back(cyc);
      rx_busy = 1'b1;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected_frame: start at cycle %0d with empty scoreboard, required no frame", cyc);
        repeat (20) @(negedge clk);
      end else begin
        e       = sb.pop_front();
        errs    = 0;
        got     = '0;
        aborted = 1'b0;
        for (int k = 0; k < 10 * e.div; k++) begin
          if (k > 0) @(negedge clk);
          if (!rx_en) begin
            aborted = 1'b1;
            break;
          end
          bitn    = k / e.div;
          exp_bit = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : e.data[bitn-1];
          if (bus.ser_tx !== exp_bit) errs++;
          if (bitn >= 1 && bitn <= 8 && (k % e.div) == e.div / 2) got[bitn-1] = bus.ser_tx;
        end
        if (!aborted) begin
          n_checks++;
          if (errs == 0 && got === e.data) n_pass++;
          else $display("FAIL rx_frame: decoded %02h with %0d bad line cycles (div %0d), required %02h with 0",
                        got, errs, e.div, e.data);
          frames_done++;
        end
      end
      rx_busy = 1'b0;
    end
  end

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rx_busy && bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    bus.wr          = 1'b0;
    bus.data        = '0;
    bus.clr_ovf     = 1'b0;
    bus.cfg_divider = 4;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ser_tx !== 1'b1) $display("FAIL reset_ser_tx: got %b, required 1", bus.ser_tx); else n_pass++;
    n_checks++;
    if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b, required 1", bus.empty); else n_pass++;
    n_checks++;
    if (bus.full !== 1'b0) $display("FAIL reset_full: got %b, required 0", bus.full); else n_pass++;
    n_checks++;
    if (bus.level !== '0) $display("FAIL reset_level: got %0d, required 0", bus.level); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b, required 0", bus.overflow); else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;
  endtask

  task automatic test_basic_frame();
    int wc, n0, f0, st, fall;
    bit ok;
    n0 = starts.size();
    f0 = frames_done;
    @(negedge clk);
    bus.cfg_divider = 4;
    bus.wr          = 1'b1;
    bus.data        = 8'h55;
    wc              = cyc;
    sb.push_back('{8'h55, 4});
    @(negedge clk);
    bus.wr = 1'b0;
    n_checks++;
    if (bus.level !== 5'd1 || bus.empty !== 1'b0)
      $display("FAIL basic_visible: level %0d empty %b, required 1 0", bus.level, bus.empty);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.ser_tx !== 1'b0 || bus.empty !== 1'b1 || bus.level !== 5'd0)
      $display("FAIL basic_popped: ser_tx %b empty %b level %0d, required 0 1 0", bus.ser_tx, bus.empty, bus.level);
    else n_pass++;
    fall = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    st = (starts.size() > n0) ? starts[n0] : -1000;
    n_checks++;
    if (st - wc != 2) $display("FAIL basic_start_latency: got %0d, required 2", st - wc); else n_pass++;
    n_checks++;
    if (fall - st != 40) $display("FAIL basic_busy_fall: got %0d clocks, required 40", fall - st); else n_pass++;
    wait_drain(200, ok);
    n_checks++;
    if (!ok || frames_done != f0 + 1)
      $display("FAIL basic_frames: drained %0d frames %0d, required 1 1", ok, frames_done - f0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n0, f0, fall, d;
    bit ok;
    n0 = starts.size();
    f0 = frames_done;
    @(negedge clk);
    bus.cfg_divider = 217;
    bus.wr          = 1'b1;
    bus.data        = 8'h41;
    sb.push_back('{8'h41, 217});
    @(negedge clk);
    bus.data = 8'h0D;
    sb.push_back('{8'h0D, 217});
    @(negedge clk);
    bus.wr = 1'b0;
    fall = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    d = (starts.size() > n0 + 1) ? starts[n0+1] - starts[n0] : -1;
    n_checks++;
    if (d != 2170) $display("FAIL b2b_second_start: got %0d, required 2170", d); else n_pass++;
    d = (starts.size() > n0) ? fall - starts[n0] : -1;
    n_checks++;
    if (d != 4340) $display("FAIL b2b_total_length: got %0d, required 4340", d); else n_pass++;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || frames_done != f0 + 2)
      $display("FAIL b2b_frames: drained %0d frames %0d, required 1 2", ok, frames_done - f0);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int f0;
    bit ok;
    f0 = frames_done;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.cfg_divider = 1000;
      bus.wr          = 1'b1;
      bus.data        = 8'(8'hA0 + i);
      sb.push_back('{8'(8'hA0 + i), (i == 0) ? 1000 : 2});
    end
    @(negedge clk);
    n_checks++;
    if (bus.full !== 1'b1 || bus.level !== 5'd16 || bus.overflow !== 1'b0)
      $display("FAIL fill_full: full %b level %0d ovf %b, required 1 16 0", bus.full, bus.level, bus.overflow);
    else n_pass++;
    bus.data = 8'hEE;
    @(negedge clk);
    bus.wr = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16)
      $display("FAIL drop_sets_ovf: ovf %b level %0d, required 1 16", bus.overflow, bus.level);
    else n_pass++;
    bus.wr      = 1'b1;
    bus.data    = 8'hEF;
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.wr      = 1'b0;
    bus.clr_ovf = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b, required 1", bus.overflow); else n_pass++;
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.full !== 1'b1)
      $display("FAIL clr_ovf: ovf %b full %b, required 0 1", bus.overflow, bus.full);
    else n_pass++;
    bus.cfg_divider = 2;
    wait_drain(12000, ok);
    n_checks++;
    if (!ok || frames_done != f0 + 17)
      $display("FAIL fill_frames: drained %0d frames %0d, required 1 17", ok, frames_done - f0);
    else n_pass++;
  endtask

  task automatic test_divider_change();
    int n0, f0, d;
    bit ok;
    n0 = starts.size();
    f0 = frames_done;
    @(negedge clk);
    bus.cfg_divider = 4;
    bus.wr          = 1'b1;
    bus.data        = 8'h3C;
    sb.push_back('{8'h3C, 4});
    @(negedge clk);
    bus.data = 8'hA5;
    sb.push_back('{8'hA5, 8});
    @(negedge clk);
    bus.wr = 1'b0;
    for (int i = 0; i < 20 && starts.size() <= n0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    bus.cfg_divider = 8;
    wait_drain(300, ok);
    n_checks++;
    if (!ok || frames_done != f0 + 2)
      $display("FAIL divchg_frames: drained %0d frames %0d, required 1 2", ok, frames_done - f0);
    else n_pass++;
    d = (starts.size() > n0 + 1) ? starts[n0+1] - starts[n0] : -1;
    n_checks++;
    if (d != 40) $display("FAIL divchg_first_len: got %0d, required 40", d); else n_pass++;
    @(negedge clk);
    bus.cfg_divider = 0;
    bus.wr          = 1'b1;
    bus.data        = 8'h96;
    sb.push_back('{8'h96, 2});
    @(negedge clk);
    bus.wr = 1'b0;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || frames_done != f0 + 3)
      $display("FAIL div0_frames: drained %0d frames %0d, required 1 3", ok, frames_done - f0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n0, s, lows;
    n0 = starts.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cfg_divider = 4;
      bus.wr          = 1'b1;
      bus.data        = 8'(8'h11 * (i + 1));
      sb.push_back('{8'(8'h11 * (i + 1)), 4});
    end
    @(negedge clk);
    bus.wr = 1'b0;
    for (int i = 0; i < 20 && starts.size() <= n0; i++) @(negedge clk);
    s = (starts.size() > n0) ? starts[n0] : cyc;
    for (int i = 0; i < 40 && cyc < s + 17; i++) @(negedge clk);
    rx_en  = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ser_tx !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL rst_mid_line: ser_tx %b busy %b, required 1 0", bus.ser_tx, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1)
      $display("FAIL rst_mid_flush: level %0d empty %b, required 0 1", bus.level, bus.empty);
    else n_pass++;
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lows   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ser_tx !== 1'b1 || bus.level !== 5'd0) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL rst_no_more_frames: got %0d active cycles, required 0", lows); else n_pass++;
    rx_en = 1'b1;
  endtask

  task automatic test_wrap_loopback();
    int f0, sent, maxlev;
    bit ok;
    logic [7:0] b;
    f0     = frames_done;
    sent   = 0;
    maxlev = 0;
    bus.cfg_divider = 8;
    for (int t = 0; t < 8000 && sent < 40; t++) begin
      @(negedge clk);
      if (int'(bus.level) > maxlev) maxlev = int'(bus.level);
      if (bus.level < 5'd3) begin
        b        = 8'($urandom);
        bus.wr   = 1'b1;
        bus.data = b;
        sb.push_back('{b, 8});
        sent++;
      end else begin
        bus.wr = 1'b0;
      end
    end
    @(negedge clk);
    bus.wr = 1'b0;
    wait_drain(1000, ok);
    n_checks++;
    if (!ok || sent != 40 || frames_done != f0 + 40)
      $display("FAIL wrap_frames: drained %0d sent %0d frames %0d, required 1 40 40", ok, sent, frames_done - f0);
    else n_pass++;
    n_checks++;
    if (maxlev > 3) $display("FAIL wrap_level: max %0d, required at most 3", maxlev); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_fill_overflow();
    test_divider_change();
    test_reset_mid_frame();
    test_wrap_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
